// File: rtl/dca_matrix_store_sequencer_pkg.sv
// Shared definitions for the DCA matrix store/load sequencers: width derivations,
// FSM state encoding, AXI response constant and the burst beat-count helper.
package dca_matrix_store_sequencer_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAw,
        StSeg,
        StWaitB,
        StDone
    } state_e;

    localparam logic [1:0] BRESP_OKAY = 2'b00;

    // Width of the rows-1 / cols-1 fields for a given matrix dimension.
    function automatic int unsigned bw_num_m1(input int unsigned matrix_size);
        return $clog2(matrix_size);
    endfunction

    // Bytes carried by one AXI data beat.
    function automatic int unsigned beat_bytes(input int unsigned bw_row);
        return bw_row / 8;
    endfunction

    // Beats needed to cover 'bytes' starting 'off' bytes into the first beat.
    function automatic int unsigned beat_count(input int unsigned off,
                                               input int unsigned bytes,
                                               input int unsigned bb);
        return (off + bytes + bb - 1) / bb;
    endfunction

endpackage

// File: rtl/dca_matrix_store_sequencer_if.sv
// Instruction, AXI write-address, merger segment and B-response signals of the
// matrix store sequencer. 'master' is the sequencer's view, 'slave' its environment.
interface dca_matrix_store_sequencer_if
    import dca_matrix_store_sequencer_pkg::*;
#(
    parameter int unsigned BW_ADDR     = 32,
    parameter int unsigned BW_ROW      = 128,
    parameter int unsigned MATRIX_SIZE = 4
);
    localparam int unsigned BW_NUM_M1 = bw_num_m1(MATRIX_SIZE);

    logic                   inst_valid;
    logic                   inst_ready;
    logic [BW_ADDR-1:0]     inst_addr;
    logic [15:0]            inst_stride_ls3;
    logic [BW_NUM_M1-1:0]   inst_num_row_m1;
    logic [BW_NUM_M1-1:0]   inst_num_col_m1;

    logic                   awvalid;
    logic                   awready;
    logic [BW_ADDR-1:0]     awaddr;
    logic [7:0]             awlen;

    logic                   seg_valid;
    logic                   seg_ready;
    logic [$clog2(BW_ROW)-1:0] seg_bitaddr;
    logic [7:0]             seg_alen;
    logic                   seg_last_beat;
    logic                   seg_last_row;

    logic                   bvalid;
    logic                   bready;
    logic [1:0]             bresp;

    modport master (
        input  inst_valid, inst_addr, inst_stride_ls3, inst_num_row_m1, inst_num_col_m1,
        output inst_ready,
        output awvalid, awaddr, awlen,
        input  awready,
        output seg_valid, seg_bitaddr, seg_alen, seg_last_beat, seg_last_row,
        input  seg_ready,
        input  bvalid, bresp,
        output bready
    );

    modport slave (
        output inst_valid, inst_addr, inst_stride_ls3, inst_num_row_m1, inst_num_col_m1,
        input  inst_ready,
        input  awvalid, awaddr, awlen,
        output awready,
        input  seg_valid, seg_bitaddr, seg_alen, seg_last_beat, seg_last_row,
        output seg_ready,
        output bvalid, bresp,
        input  bready
    );

endinterface

// File: rtl/dca_store_row_geom.sv
// Row geometry: byte offset of a row within its first beat, the beat-aligned burst
// address and the burst length. Purely combinational; shared with the load sequencer.
module dca_store_row_geom
    import dca_matrix_store_sequencer_pkg::*;
#(
    parameter int unsigned BW_ADDR     = 32,
    parameter int unsigned BW_ROW      = 128,
    parameter int unsigned BW_ELEMENT  = 32,
    parameter int unsigned MATRIX_SIZE = 4
) (
    input  logic [BW_ADDR-1:0]                       row_addr,
    input  logic [bw_num_m1(MATRIX_SIZE)-1:0]        num_col_m1,
    output logic [$clog2(beat_bytes(BW_ROW))-1:0]    off,
    output logic [BW_ADDR-1:0]                       awaddr,
    output logic [7:0]                               awlen
);
    localparam int unsigned BEAT_BYTES = beat_bytes(BW_ROW);
    localparam int unsigned BW_OFF     = $clog2(BEAT_BYTES);

    int unsigned row_bytes;
    int unsigned beats;

    // Split the row address into beat base and offset, then size the burst.
    always_comb begin
        row_bytes = 0;
        beats     = 0;
        off       = row_addr[BW_OFF-1:0];
        awaddr    = {row_addr[BW_ADDR-1:BW_OFF], {BW_OFF{1'b0}}};
        row_bytes = (32'(num_col_m1) + 1) * BW_ELEMENT / 8;
        beats     = beat_count(32'(off), row_bytes, BEAT_BYTES);
        awlen     = 8'(beats - 1);
    end

endmodule

// File: rtl/dca_matrix_store_sequencer.sv
// Matrix store sequencer: accepts one store instruction, issues one AXI write burst
// per row with strict AW-then-segments ordering, and drives the per-beat merger
// control stream. Completes once every B response is back.
// Optional feature: define DCA_STORE_SEQ_BRESP_CHECK_EN to flag non-OKAY B responses
// on the sticky 'error' output; otherwise 'error' is tied low.
module dca_matrix_store_sequencer
    import dca_matrix_store_sequencer_pkg::*;
#(
    parameter int unsigned BW_ADDR     = 32,
    parameter int unsigned BW_ROW      = 128,
    parameter int unsigned BW_ELEMENT  = 32,
    parameter int unsigned MATRIX_SIZE = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    dca_matrix_store_sequencer_if.master  bus,
    output logic                          busy,
    output logic                          done,
    output logic                          error
);
    localparam int unsigned BW_NUM_M1  = bw_num_m1(MATRIX_SIZE);
    localparam int unsigned BEAT_BYTES = beat_bytes(BW_ROW);
    localparam int unsigned BW_OFF     = $clog2(BEAT_BYTES);
    localparam int unsigned BW_OUT     = BW_NUM_M1 + 1;

    state_e               state_q, state_d;
    logic [BW_ADDR-1:0]   row_addr_q, row_addr_d;
    logic [15:0]          stride_q, stride_d;
    logic [BW_NUM_M1-1:0] num_row_q, num_row_d;
    logic [BW_NUM_M1-1:0] num_col_q, num_col_d;
    logic [BW_NUM_M1-1:0] row_q, row_d;
    logic [7:0]           beat_q, beat_d;
    logic [BW_OUT-1:0]    outstanding_q, outstanding_d;

    logic [BW_OFF-1:0]    row_off;
    logic [BW_ADDR-1:0]   row_awaddr;
    logic [7:0]           row_awlen;
    logic [BW_ADDR-1:0]   stride_bytes;
    logic                 aw_fire;
    logic                 b_fire;

    dca_store_row_geom #(
        .BW_ADDR     (BW_ADDR),
        .BW_ROW      (BW_ROW),
        .BW_ELEMENT  (BW_ELEMENT),
        .MATRIX_SIZE (MATRIX_SIZE)
    ) u_row_geom (
        .row_addr   (row_addr_q),
        .num_col_m1 (num_col_q),
        .off        (row_off),
        .awaddr     (row_awaddr),
        .awlen      (row_awlen)
    );

    // Row-to-row address step; accumulated instead of multiplied by the row index.
    assign stride_bytes = BW_ADDR'({stride_q, 3'b000});

    // Handshake decode; a B with nothing outstanding is dropped.
    always_comb begin
        aw_fire = (state_q == StAw) && bus.awready;
        b_fire  = bus.bvalid && (outstanding_q != '0);
    end

    // Outstanding-burst counter: AW adds, B removes, both together cancel.
    always_comb begin
        outstanding_d = outstanding_q;
        case ({aw_fire, b_fire})
            2'b10:   outstanding_d = outstanding_q + BW_OUT'(1);
            2'b01:   outstanding_d = outstanding_q - BW_OUT'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    // Next-state logic: instruction latch, row walk and completion.
    always_comb begin
        state_d    = state_q;
        row_addr_d = row_addr_q;
        stride_d   = stride_q;
        num_row_d  = num_row_q;
        num_col_d  = num_col_q;
        row_d      = row_q;
        beat_d     = beat_q;
        unique case (state_q)
            StIdle: begin
                if (bus.inst_valid) begin
                    row_addr_d = bus.inst_addr;
                    stride_d   = bus.inst_stride_ls3;
                    num_row_d  = bus.inst_num_row_m1;
                    num_col_d  = bus.inst_num_col_m1;
                    row_d      = '0;
                    state_d    = StAw;
                end
            end
            StAw: begin
                if (bus.awready) begin
                    beat_d  = '0;
                    state_d = StSeg;
                end
            end
            StSeg: begin
                if (bus.seg_ready) begin
                    beat_d = beat_q + 8'd1;
                    if (beat_q == row_awlen) begin
                        if (row_q == num_row_q) begin
                            state_d = StWaitB;
                        end else begin
                            row_d      = row_q + BW_NUM_M1'(1);
                            row_addr_d = row_addr_q + stride_bytes;
                            state_d    = StAw;
                        end
                    end
                end
            end
            // Looking at the next count lets done follow the last B by one cycle.
            StWaitB: begin
                if (outstanding_d == '0) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset abandons any instruction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            row_addr_q    <= '0;
            stride_q      <= '0;
            num_row_q     <= '0;
            num_col_q     <= '0;
            row_q         <= '0;
            beat_q        <= '0;
            outstanding_q <= '0;
        end else begin
            state_q       <= state_d;
            row_addr_q    <= row_addr_d;
            stride_q      <= stride_d;
            num_row_q     <= num_row_d;
            num_col_q     <= num_col_d;
            row_q         <= row_d;
            beat_q        <= beat_d;
            outstanding_q <= outstanding_d;
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        bus.inst_ready    = (state_q == StIdle);
        bus.awvalid       = (state_q == StAw);
        bus.awaddr        = row_awaddr;
        bus.awlen         = row_awlen;
        bus.seg_valid     = (state_q == StSeg);
        bus.seg_bitaddr   = (beat_q == 8'd0) ? {row_off, 3'b000} : '0;
        bus.seg_alen      = row_awlen;
        bus.seg_last_beat = (state_q == StSeg) && (beat_q == row_awlen);
        bus.seg_last_row  = (state_q == StSeg) && (row_q == num_row_q);
        bus.bready        = 1'b1;
        busy              = (state_q != StIdle);
        done              = (state_q == StDone);
    end

`ifdef DCA_STORE_SEQ_BRESP_CHECK_EN
    logic error_q, error_d;

    // Sticky slave-error flag, cleared when the next instruction is accepted.
    always_comb begin
        error_d = error_q;
        if ((state_q == StIdle) && bus.inst_valid) begin
            error_d = 1'b0;
        end else if (b_fire && (bus.bresp != BRESP_OKAY)) begin
            error_d = 1'b1;
        end
    end

    // Error flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign error = error_q;
`else
    logic unused_bresp;
    assign unused_bresp = ^bus.bresp;
    assign error        = 1'b0;
`endif

endmodule

// File: tb/tb_dca_matrix_store_sequencer.sv
// Scoreboard bench for the matrix store sequencer: directed instructions push their
// hand-computed AW and segment expectations; a monitor pops and compares on each
// handshake, and a responder returns one B per accepted AW a fixed delay later.
module tb_dca_matrix_store_sequencer;

    localparam int B_LAT = 2;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } aw_exp_t;

    typedef struct {
        logic [6:0] bitaddr;
        logic [7:0] alen;
        logic       lb;
        logic       lr;
    } seg_exp_t;

    typedef struct {
        int         due;
        logic [1:0] resp;
    } b_pend_t;

    logic clk;
    logic rst;
    logic busy;
    logic done;
    logic error;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int aw_cnt   = 0;
    int b_acc    = 0;
    int done_cnt = 0;
    int exp_aws  = 0;
    logic exp_error = 1'b0;

    aw_exp_t    aw_q[$];
    seg_exp_t   seg_q[$];
    b_pend_t    bq[$];
    logic [1:0] resp_plan[$];

    aw_exp_t  mon_aw;
    seg_exp_t mon_seg;
    b_pend_t  drv_b;

    dca_matrix_store_sequencer_if #(
        .BW_ADDR     (32),
        .BW_ROW      (128),
        .MATRIX_SIZE (4)
    ) bus ();

    dca_matrix_store_sequencer #(
        .BW_ADDR     (32),
        .BW_ROW      (128),
        .BW_ELEMENT  (32),
        .MATRIX_SIZE (4)
    ) u_dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .busy  (busy),
        .done  (done),
        .error (error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_aw(input logic [31:0] a, input logic [7:0] l);
        aw_exp_t e;
        e.addr = a;
        e.len  = l;
        aw_q.push_back(e);
    endtask

    task automatic push_seg(input logic [6:0] ba, input logic [7:0] al, input logic lb,
                            input logic lr);
        seg_exp_t e;
        e.bitaddr = ba;
        e.alen    = al;
        e.lb      = lb;
        e.lr      = lr;
        seg_q.push_back(e);
    endtask

    task automatic issue(input logic [31:0] a, input logic [15:0] s, input logic [1:0] nr,
                         input logic [1:0] nc);
        bit got = 0;
        aw_cnt = 0;
        b_acc  = 0;
        @(posedge clk);
        #1;
        bus.inst_addr       = a;
        bus.inst_stride_ls3 = s;
        bus.inst_num_row_m1 = nr;
        bus.inst_num_col_m1 = nc;
        bus.inst_valid      = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.inst_ready) begin
                got = 1;
                break;
            end
        end
        check("inst_accept", 64'(got), 64'd1);
        @(posedge clk);
        #1;
        bus.inst_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int start = done_cnt;
        bit got = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (done_cnt != start) begin
                got = 1;
                break;
            end
        end
        check("done_seen", 64'(got), 64'd1);
    endtask

    task automatic check_drained();
        check("aw_q_empty", 64'(aw_q.size()), 64'd0);
        check("seg_q_empty", 64'(seg_q.size()), 64'd0);
    endtask

    // B responder: one response per accepted AW, B_LAT cycles after it.
    initial begin
        bus.bvalid = 1'b0;
        bus.bresp  = 2'b00;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (rst) begin
                bus.bvalid = 1'b0;
                bus.bresp  = 2'b00;
            end else if (bq.size() > 0 && bq[0].due <= cyc) begin
                drv_b      = bq.pop_front();
                bus.bvalid = 1'b1;
                bus.bresp  = drv_b.resp;
            end else begin
                bus.bvalid = 1'b0;
                bus.bresp  = 2'b00;
            end
        end
    end

    // Monitor: compare every AW and segment handshake, count Bs, check completion.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.awvalid && bus.awready) begin
                    if (aw_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL aw_unexpected actual=%0h required=none", bus.awaddr);
                    end else begin
                        mon_aw = aw_q.pop_front();
                        check("awaddr", 64'(bus.awaddr), 64'(mon_aw.addr));
                        check("awlen", 64'(bus.awlen), 64'(mon_aw.len));
                    end
                    aw_cnt++;
                    drv_b.due  = cyc + B_LAT;
                    drv_b.resp = (resp_plan.size() > 0) ? resp_plan.pop_front() : 2'b00;
                    bq.push_back(drv_b);
                end
                if (bus.seg_valid && bus.seg_ready) begin
                    if (seg_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL seg_unexpected actual=%0h required=none",
                                 bus.seg_bitaddr);
                    end else begin
                        mon_seg = seg_q.pop_front();
                        check("seg_bitaddr", 64'(bus.seg_bitaddr), 64'(mon_seg.bitaddr));
                        check("seg_alen", 64'(bus.seg_alen), 64'(mon_seg.alen));
                        check("seg_last_beat", 64'(bus.seg_last_beat), 64'(mon_seg.lb));
                        check("seg_last_row", 64'(bus.seg_last_row), 64'(mon_seg.lr));
                    end
                end
                if (bus.bvalid) b_acc++;
                if (done) begin
                    check("done_after_all_b", 64'(b_acc), 64'(aw_cnt));
                    check("done_aw_count", 64'(aw_cnt), 64'(exp_aws));
                    check("done_error", 64'(error), 64'(exp_error));
                    done_cnt++;
                end
            end
        end
    end

    initial begin
        rst                 = 1'b1;
        bus.inst_valid      = 1'b0;
        bus.inst_addr       = '0;
        bus.inst_stride_ls3 = '0;
        bus.inst_num_row_m1 = '0;
        bus.inst_num_col_m1 = '0;
        bus.awready         = 1'b1;
        bus.seg_ready       = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state.
        @(negedge clk);
        check("rst_inst_ready", 64'(bus.inst_ready), 64'd1);
        check("rst_awvalid", 64'(bus.awvalid), 64'd0);
        check("rst_seg_valid", 64'(bus.seg_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_awaddr", 64'(bus.awaddr), 64'd0);
        check("rst_awlen", 64'(bus.awlen), 64'd0);
        check("rst_seg_bitaddr", 64'(bus.seg_bitaddr), 64'd0);
        check("rst_seg_last_beat", 64'(bus.seg_last_beat), 64'd0);
        check("rst_seg_last_row", 64'(bus.seg_last_row), 64'd0);
        check("rst_bready", 64'(bus.bready), 64'd1);

        // 4x4 at 0x1000, 16-byte stride; B of row r lands with AW of row r+1.
        exp_error = 1'b0;
        exp_aws   = 4;
        for (int r = 0; r < 4; r++) begin
            push_aw(32'h1000 + 32'(r) * 32'h10, 8'd0);
            push_seg(7'd0, 8'd0, 1'b1, (r == 3));
        end
        issue(32'h1000, 16'd2, 2'd3, 2'd3);
        wait_done(200);
        check_drained();

        // Unaligned 1x4 at 0x1004: two beats from 0x1000.
        exp_aws = 1;
        push_aw(32'h1000, 8'd1);
        push_seg(7'd32, 8'd1, 1'b0, 1'b1);
        push_seg(7'd0, 8'd1, 1'b1, 1'b1);
        issue(32'h1004, 16'd0, 2'd0, 2'd3);
        wait_done(200);
        check_drained();

        // awready held low 5 cycles on a 1x1 at 0x2008.
        exp_aws     = 1;
        bus.awready = 1'b0;
        push_aw(32'h2000, 8'd0);
        push_seg(7'd64, 8'd0, 1'b1, 1'b1);
        issue(32'h2008, 16'd0, 2'd0, 2'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_awvalid", 64'(bus.awvalid), 64'd1);
            check("stall_awaddr", 64'(bus.awaddr), 64'h2000);
            check("stall_seg_valid", 64'(bus.seg_valid), 64'd0);
        end
        @(posedge clk);
        #1 bus.awready = 1'b1;
        wait_done(200);
        check_drained();

        // 2x2 at 0x3000 with a SLVERR on row 1.
`ifdef DCA_STORE_SEQ_BRESP_CHECK_EN
        exp_error = 1'b1;
`else
        exp_error = 1'b0;
`endif
        exp_aws = 2;
        resp_plan.push_back(2'b00);
        resp_plan.push_back(2'b10);
        push_aw(32'h3000, 8'd0);
        push_seg(7'd0, 8'd0, 1'b1, 1'b0);
        push_aw(32'h3020, 8'd0);
        push_seg(7'd0, 8'd0, 1'b1, 1'b1);
        issue(32'h3000, 16'd4, 2'd1, 2'd1);
        wait_done(200);
        @(negedge clk);
        check("error_sticky", 64'(error), 64'(exp_error));
        check_drained();

        // 4x4 at 0x4000, reset while row 2's segment is stalled.
        exp_error = 1'b0;
        exp_aws   = 4;
        for (int r = 0; r < 4; r++) begin
            push_aw(32'h4000 + 32'(r) * 32'h10, 8'd0);
            push_seg(7'd0, 8'd0, 1'b1, (r == 3));
        end
        issue(32'h4000, 16'd2, 2'd3, 2'd3);
        @(negedge clk);
        check("error_cleared_on_accept", 64'(error), 64'd0);
        begin
            bit got = 0;
            for (int i = 0; i < 100; i++) begin
                @(posedge clk);
                if (aw_cnt >= 3) begin
                    got = 1;
                    break;
                end
            end
            check("row2_aw_seen", 64'(got), 64'd1);
        end
        #1 bus.seg_ready = 1'b0;
        @(negedge clk);
        check("row2_seg_valid", 64'(bus.seg_valid), 64'd1);
        check("row2_seg_last_row", 64'(bus.seg_last_row), 64'd0);
        #1 rst = 1'b1;
        #1;
        check("abort_awvalid", 64'(bus.awvalid), 64'd0);
        check("abort_seg_valid", 64'(bus.seg_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        aw_q.delete();
        seg_q.delete();
        bq.delete();
        resp_plan.delete();
        bus.seg_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_inst_ready", 64'(bus.inst_ready), 64'd1);
        check("post_rst_busy", 64'(busy), 64'd0);
        check("post_rst_awvalid", 64'(bus.awvalid), 64'd0);
        check("post_rst_seg_valid", 64'(bus.seg_valid), 64'd0);

        // Clean instruction after the abort.
        exp_aws = 1;
        push_aw(32'h1000, 8'd1);
        push_seg(7'd32, 8'd1, 1'b0, 1'b1);
        push_seg(7'd0, 8'd1, 1'b1, 1'b1);
        issue(32'h1004, 16'd0, 2'd0, 2'd3);
        wait_done(200);
        check_drained();
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
